// File: rtl/pad_pwr_seq_pkg.sv
// Shared types and constants for the pad-ring power-up sequencer.
// Holds the state encoding, default timing, and the pad-output decode.
package pad_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_DEB     = 3'd1,
        ST_REL_RET = 3'd2,
        ST_EN_IO   = 3'd3,
        ST_RUN     = 3'd4
    } pwr_state_e;

    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_DEBOUNCE_CNT = 200;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_STEP_DLY     = 16;

    typedef struct packed {
        logic io_ret;
        logic io_oe_en;
        logic core_rst_n;
    } pad_out_t;

    localparam pad_out_t PAD_OUT_SAFE = '{io_ret: 1'b1, io_oe_en: 1'b0, core_rst_n: 1'b0};

    // Each step out of retention peels off one more level of protection.
    function automatic pad_out_t decode_out(input pwr_state_e st);
        pad_out_t o;
        o = PAD_OUT_SAFE;
        case (st)
            ST_REL_RET: o = '{io_ret: 1'b0, io_oe_en: 1'b0, core_rst_n: 1'b0};
            ST_EN_IO:   o = '{io_ret: 1'b0, io_oe_en: 1'b1, core_rst_n: 1'b0};
            ST_RUN:     o = '{io_ret: 1'b0, io_oe_en: 1'b1, core_rst_n: 1'b1};
            default:    o = PAD_OUT_SAFE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pad_pwr_sync.sv
// N-stage reset-to-0 synchronizer for one asynchronous supply-good indication.
module pad_pwr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_pwr_seq.sv
// Power-up sequencer for the pad ring: debounces VDD/VDDIO good, then releases
// retention, enables pad drivers and releases core reset; falls back safe on loss.
module pad_pwr_seq
    import pad_pwr_seq_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STEP_DLY     = DEF_STEP_DLY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vdd_ok_i,
    input  logic       vddio_ok_i,
    input  logic       sw_hold_i,
    input  logic       fault_clr_i,
    output logic       io_ret_o,
    output logic       io_oe_en_o,
    output logic       core_rst_n_o,
    output logic [2:0] pwr_state_o,
    output logic       pwr_fault_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic vdd_s, vddio_s, ok_s;
    pwr_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic fault_q, fault_d;
    pad_out_t out_q;

    pad_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (vdd_ok_i),
        .q_o   (vdd_s)
    );

    pad_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync_vddio (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (vddio_ok_i),
        .q_o   (vddio_s)
    );

    assign ok_s = vdd_s & vddio_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q & ~fault_clr_i;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (ok_s && !sw_hold_i) state_d = ST_DEB;
            end
            ST_DEB: begin
                if (!ok_s || sw_hold_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_REL_RET;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REL_RET, ST_EN_IO, ST_RUN: begin
                // Loss is checked first so a coincident hold cannot mask the fault.
                if (!ok_s) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end else if (sw_hold_i) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end else if (state_q == ST_RUN) begin
                    cnt_d = '0;
                end else if (cnt_q == STEP_LAST) begin
                    state_d = (state_q == ST_REL_RET) ? ST_EN_IO : ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            out_q   <= PAD_OUT_SAFE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            out_q   <= decode_out(state_d);
        end
    end

    assign io_ret_o     = out_q.io_ret;
    assign io_oe_en_o   = out_q.io_oe_en;
    assign core_rst_n_o = out_q.core_rst_n;
    assign pwr_state_o  = state_q;
    assign pwr_fault_o  = fault_q;

endmodule

// File: tb/tb_pad_pwr_seq.sv
// Directed bench for pad_pwr_seq: expected output tuples are queued as stimulus
// is applied and compared when the sequencer is sampled.
module tb_pad_pwr_seq;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n, vdd, vddio, hold, clr;
    logic       io_ret, io_oe, core_rstn, fault;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic       ret, oe, rstn, flt;
    } exp_t;

    exp_t sb[$];

    pad_pwr_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vdd_ok_i     (vdd),
        .vddio_ok_i   (vddio),
        .sw_hold_i    (hold),
        .fault_clr_i  (clr),
        .io_ret_o     (io_ret),
        .io_oe_en_o   (io_oe),
        .core_rst_n_o (core_rstn),
        .pwr_state_o  (state),
        .pwr_fault_o  (fault)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic ret,
                        input logic oe, input logic rstn, input logic flt);
        exp_t e;
        e.tag = tag; e.st = st; e.ret = ret; e.oe = oe; e.rstn = rstn; e.flt = flt;
        sb.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".state"},      32'(state),     32'(e.st));
            chk({e.tag, ".io_ret"},     32'(io_ret),    32'(e.ret));
            chk({e.tag, ".io_oe_en"},   32'(io_oe),     32'(e.oe));
            chk({e.tag, ".core_rst_n"}, 32'(core_rstn), 32'(e.rstn));
            chk({e.tag, ".pwr_fault"},  32'(fault),     32'(e.flt));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ret(output int n, input int bound);
        n = 0;
        while (io_ret !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; vdd = 1'b0; vddio = 1'b0; hold = 1'b0; clr = 1'b0;
        ticks(3);
        push("reset", 3'd0, 1, 0, 0, 0); pop_cmp();
        rst_n = 1'b1;
        ticks(2);
        push("idle_no_supply", 3'd0, 1, 0, 0, 0); pop_cmp();

        // Full power-up with default timing
        vdd = 1'b1; vddio = 1'b1;
        push("deb_entry", 3'd1, 1, 0, 0, 0);
        ticks(3); pop_cmp();
        wait_ret(cyc, 400);
        cyc += 3;
        chk("ret_release_latency_in_202_204", 32'(cyc >= 202 && cyc <= 204), 1);
        push("rel_ret", 3'd2, 0, 0, 0, 0); pop_cmp();
        push("rel_ret_hold", 3'd2, 0, 0, 0, 0); ticks(15); pop_cmp();
        push("en_io", 3'd3, 0, 1, 0, 0); ticks(1); pop_cmp();
        push("en_io_hold", 3'd3, 0, 1, 0, 0); ticks(15); pop_cmp();
        push("run", 3'd4, 0, 1, 1, 0); ticks(1); pop_cmp();

        // VDD loss in RUN, then clear the sticky fault
        vdd = 1'b0;
        push("loss_sync_delay", 3'd4, 0, 1, 1, 0); ticks(2); pop_cmp();
        push("loss_safe", 3'd0, 1, 0, 0, 1); ticks(1); pop_cmp();
        clr = 1'b1; ticks(1); clr = 1'b0;
        push("fault_cleared", 3'd0, 1, 0, 0, 0); pop_cmp();

        // VDDIO glitch during debounce restarts the whole debounce
        vdd = 1'b1;
        ticks(3 + 150);
        push("deb_150", 3'd1, 1, 0, 0, 0); pop_cmp();
        vddio = 1'b0;
        ticks(3);
        push("deb_abort", 3'd0, 1, 0, 0, 0); pop_cmp();
        vddio = 1'b1;
        wait_ret(cyc, 400);
        chk("redebounce_latency_in_202_204", 32'(cyc >= 202 && cyc <= 204), 1);

        // Software hold in EN_IO
        ticks(16);
        push("en_io_pre_hold", 3'd3, 0, 1, 0, 0); pop_cmp();
        hold = 1'b1;
        push("hold_off", 3'd0, 1, 0, 0, 0); ticks(1); pop_cmp();
        push("hold_stays_off", 3'd0, 1, 0, 0, 0); ticks(4); pop_cmp();
        hold = 1'b0;
        wait_ret(cyc, 400);
        chk("hold_release_latency", 32'(cyc), 201);

        // Asynchronous reset with the clock stopped
        ticks(16);
        push("en_io_pre_reset", 3'd3, 0, 1, 0, 0); pop_cmp();
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1 push("async_reset", 3'd0, 1, 0, 0, 0); pop_cmp();
        #2 rst_n = 1'b1;
        #2 clk_en = 1'b1;

        // Supply loss coinciding with fault clear: set wins
        @(negedge clk);
        wait_ret(cyc, 400);
        chk("resequence_after_reset", 32'(io_ret), 0);
        vdd = 1'b0;
        push("loss_pre", 3'd2, 0, 0, 0, 0); ticks(2); pop_cmp();
        clr = 1'b1;
        push("set_wins", 3'd0, 1, 0, 0, 1); ticks(1); clr = 1'b0; pop_cmp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
